// File: rtl/vga_filter_pkg.sv
// Shared constants and types for the VGA scan engine and its colour-filter pipeline.
package vga_filter_pkg;
    localparam logic [2:0] MODE_PASS   = 3'd0;
    localparam logic [2:0] MODE_GREY   = 3'd1;
    localparam logic [2:0] MODE_INVERT = 3'd2;
    localparam logic [2:0] MODE_KEY    = 3'd3;
    localparam logic [2:0] MODE_BIN    = 3'd4;

    localparam logic [2:0] COLOR_RED   = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b100;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Sync flags carried down the delay line; hs/vs are "active" flags, polarity applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_t;

    typedef struct packed {
        logic       start;
        logic [2:0] mode;
        logic [2:0] key;
    } ctrl_t;
endpackage

// File: rtl/vga_filter_pipe_pix_filter.sv
// Stateless pixel colour filter followed by a single output register; output is 0 when en is low.
module pix_filter
    import vga_filter_pkg::*;
#(
    parameter int CW     = 4,
    parameter int THRESH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2:0]      mode,
    input  logic [2:0]      key,
    input  logic [3*CW-1:0] pixel,
    output logic [3*CW-1:0] pix_out
);
    localparam logic [CW+1:0] THR = (CW+2)'(THRESH);

    logic [CW-1:0]   r, g, b, grey;
    logic [CW+1:0]   sum;
    logic [2:0]      dom;
    logic [3*CW-1:0] res, pix_d, pix_q;

    always_comb begin
        r    = pixel[3*CW-1 -: CW];
        g    = pixel[2*CW-1 -: CW];
        b    = pixel[CW-1:0];
        sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        grey = sum[CW+1:2];
        // strictly dominant channel only; any tie leaves dom at 0 so it never matches a key
        dom = 3'b000;
        if (r > g && r > b)      dom = COLOR_RED;
        else if (g > r && g > b) dom = COLOR_GREEN;
        else if (b > r && b > g) dom = COLOR_BLUE;

        case (mode)
            MODE_GREY:   res = {grey, grey, grey};
            MODE_INVERT: res = ~pixel;
            MODE_KEY:    res = (!$onehot(key) || dom == key) ? pixel : {grey, grey, grey};
            MODE_BIN:    res = ({2'b00, grey} >= THR) ? '1 : '0;
            default:     res = pixel;
        endcase
        pix_d = en ? res : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) pix_q <= '0;
        else     pix_q <= pix_d;
    end

    assign pix_out = pix_q;
endmodule

// File: rtl/vga_filter_pipe.sv
// VGA scan engine: h/v counters, incremental frame-RAM address, sync delay line and per-frame filter control.
module vga_filter_pipe
    import vga_filter_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CW       = 4,
    parameter int ADDR_W   = 19,
    parameter int RAM_LAT  = 1,
    parameter int SYNC_POL = 0,
    parameter int THRESH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              filter_start,
    input  logic [2:0]        mode,
    input  logic [2:0]        key_color,
    input  logic [3*CW-1:0]   pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [3*CW-1:0]   vga_data,
    output logic              frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    ctrl_t             ctrl_q, ctrl_d;
    sync_t             raw;
    sync_t             sync_q [RAM_LAT:0];
    sync_t             sync_d [RAM_LAT:0];

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOT-1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOT-1)) ? '0 : v_q + VW'(1);
        end

        raw.hs = (h_q >= HW'(H_ACTIVE+H_FP)) && (h_q <= HW'(H_ACTIVE+H_FP+H_SYNC-1));
        raw.vs = (v_q >= VW'(V_ACTIVE+V_FP)) && (v_q <= VW'(V_ACTIVE+V_FP+V_SYNC-1));
        raw.de = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        raw.fs = (h_q == '0) && (v_q == '0);

        // running count of active pixels replaces y*H_ACTIVE+x
        addr_d = addr_q;
        if (h_d == '0 && v_d == '0) addr_d = '0;
        else if (raw.de)            addr_d = addr_q + ADDR_W'(1);

        ctrl_d = ctrl_q;
        if (raw.fs) ctrl_d = {filter_start, mode, key_color};

        sync_d[0] = raw;
        for (int i = 1; i <= RAM_LAT; i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
            ctrl_q <= '0;
            for (int i = 0; i <= RAM_LAT; i++) sync_q[i] <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
            ctrl_q <= ctrl_d;
            for (int i = 0; i <= RAM_LAT; i++) sync_q[i] <= sync_d[i];
        end
    end

    // filter input sits RAM_LAT cycles behind stage 0, where the RAM data for that pixel arrives
    pix_filter #(.CW(CW), .THRESH(THRESH)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .en      (sync_q[RAM_LAT-1].de),
        .mode    (ctrl_q.start ? ctrl_q.mode : MODE_PASS),
        .key     (ctrl_q.key),
        .pixel   (pix_data),
        .pix_out (vga_data)
    );

    assign pix_addr    = addr_q;
    assign hs          = (SYNC_POL != 0) ? sync_q[RAM_LAT].hs : ~sync_q[RAM_LAT].hs;
    assign vs          = (SYNC_POL != 0) ? sync_q[RAM_LAT].vs : ~sync_q[RAM_LAT].vs;
    assign de          = sync_q[RAM_LAT].de;
    assign frame_start = sync_q[RAM_LAT].fs;
endmodule
